bcd_counter_display: RTL
========================

# bcd_counter_display

Parametrised N-digit BCD counter with prescaled tick, four run modes, wrap detection and registered active-low seven-segment outputs. It replaces the fixed count-up display path between the board switches and the HEX0..HEX5 pins of the MAX10 top level. Digit count and tick rate are generic, and up/down/hold/load behaviour is selectable at run time.

## Interface
- `DIGITS`, default 6: number of BCD digits and seven-segment outputs, 1..8.
- `TICK_DIV`, default 50_000_000: clock cycles per count tick, ≥2; 1 Hz at 50 MHz.
- `BLANK_LZ`, default 1: when 1, leading zero digits are blanked; digit 0 is never blanked.
- `clk`  in  1: system clock, MAX10_CLK1_50 domain.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: enables tick-driven counting.
- `mode`  in  2: 00 hold, 01 up, 10 down, 11 load.
- `step`  in  1: single-cycle manual advance pulse, honoured in up/down modes regardless of `en`.
- `load_val`  in  4*DIGITS: BCD load value, digit 0 in [3:0].
- `count`  out  4*DIGITS: current BCD count.
- `hex`  out  8*DIGITS: segments, digit i in [8i+7:8i], bit order {dp,g,f,e,d,c,b,a}, active-low.
- `tick`  out  1: one-cycle prescaler pulse.
- `wrap`  out  1: one-cycle pulse on overflow or underflow.

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1 and wraps. `tick`=1 in the cycle where `pre`==TICK_DIV-1. The prescaler runs whenever `en`=1 and is held at 0 when `en`=0.
- advance = (`en` & `tick`) | `step`. Simultaneous tick and step produce a single advance, never two.
- Mode 01, up, on advance: digit 0 increments. A digit going 9→0 carries into the next digit. When all digits are 9, the count becomes all 0 and `wrap`=1.
- Mode 10, down, on advance: digit 0 decrements. A digit going 0→9 borrows from the next digit. When all digits are 0, the count becomes all 9 and `wrap`=1.
- Mode 00, hold: count is frozen. The prescaler keeps running and `tick` still pulses.
- Mode 11, load: `count` ← `load_val` on every cycle the mode is held. Any nibble greater than 9 is replaced with 9. `pre` is cleared to 0. `step` is ignored.
- Mode change takes effect on the next edge. No state is lost except in load.
- Segment encoding for digits 0–9: C0 F9 A4 B0 99 92 82 F8 80 90. Blank is FF. dp is always 1 (off).
- Leading-zero blanking (BLANK_LZ=1): digit i>0 is blanked when it and all higher digits are 0.

## Timing
- Reset values: `count`=0, `pre`=0, `tick`=0, `wrap`=0.
- `hex` resets to FF on all digits for one cycle, then follows `count`. With BLANK_LZ=0, digit 0 shows C0 and the other digits show C0.
- `tick` and `wrap` are registered.
- `count` updates on the edge that samples advance, so `count` changes in the same cycle `tick` is visible. `wrap` is asserted in that same cycle.
- `hex` is registered from `count`: one-cycle latency, so `hex` lags `count` by exactly 1 cycle.
- `rst` dominates all inputs, including mid-count and mid-load.
- `en` deasserting on a tick cycle: that tick still advances, because the tick was registered before `en` fell. The prescaler clears next cycle.
- `step` held high for k cycles produces k advances. Debouncing is the caller's responsibility.

## Structure
- Package `bcd_disp_pkg`:
  - mode constants MODE_HOLD, MODE_UP, MODE_DOWN, MODE_LOAD
  - SEG_BLANK=8'hFF
  - the 10-entry segment pattern constant
- Sub-module `seg7_decode`: combinational 4-bit BCD plus blank → 8-bit active-low segments. Instantiated DIGITS times via generate. The output register lives in the parent.
- Parent contains the prescaler, the per-digit BCD carry/borrow chain (generate loop), load clamping, blanking logic and output registers.

## Test plan
Unless noted, DIGITS=2, TICK_DIV=4, BLANK_LZ=1.
- Reset then `en`=1, mode=01: `tick` every 4 cycles; `count` steps 00→01→02. Once `hex` reflects `count`=01, `hex`={FF,F9}.
- Load 8'h98, mode=01, 2 ticks: count 98→99→00. `wrap`=1 for exactly the cycle count becomes 00. `hex` then shows {FF,C0}.
- Count 00, mode=10, one `step` with `en`=0: count becomes 99 and `wrap`=1. The prescaler stays 0 and no `tick` is seen.
- Load 8'hFA, mode=11: `count`=99 (both nibbles clamped). `pre`=0 while mode=11.
- `step` coincident with `tick` in mode=01 at count 05: result 06, not 07. Then assert `rst` mid-run: next cycle all outputs are at their reset values.
- Mode=00 for 12 cycles with `en`=1: three `tick` pulses, count unchanged. Then DIGITS=6 with BLANK_LZ=0 and count 000000: all six `hex` digits =C0.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared mode encoding and seven-segment patterns for the BCD counter display path.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Active-low {dp,g,f,e,d,c,b,a}; entry n is the pattern for digit n.
  localparam logic [9:0][7:0] SEG_PATTERNS = {
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92,
    8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/bcd_counter_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blank override.
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_blank,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank && (i_bcd <= BCD_MAX)) o_seg = SEG_PATTERNS[i_bcd];
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD counter with prescaled tick, hold/up/down/load modes, wrap pulse
// and registered active-low seven-segment outputs.
module bcd_counter_display
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS   = 6,
  parameter int TICK_DIV = 50_000_000,
  parameter int BLANK_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  step,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic [8*DIGITS-1:0]   hex,
  output logic                  tick,
  output logic                  wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]         r_pre;
  logic                  r_tick;
  logic                  r_wrap;
  logic [4*DIGITS-1:0]   r_count;
  logic [8*DIGITS-1:0]   r_hex;

  mode_e                 w_mode;
  logic                  w_pre_last;
  logic                  w_advance;
  logic [4*DIGITS-1:0]   w_up_cnt;
  logic [4*DIGITS-1:0]   w_dn_cnt;
  logic [4*DIGITS-1:0]   w_load;
  logic [DIGITS:0]       w_carry;
  logic [DIGITS:0]       w_borrow;
  logic [DIGITS:0]       w_lz;
  logic [DIGITS-1:0]     w_blank;
  logic [8*DIGITS-1:0]   w_seg;

  assign w_mode     = mode_e'(mode);
  assign w_pre_last = (r_pre == PRE_MAX);
  // A tick and a step in the same cycle collapse into one advance.
  assign w_advance  = (en & w_pre_last) | step;

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;
  assign w_lz[DIGITS] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_ld;

    assign w_dig = r_count[4*g +: 4];
    assign w_ld  = load_val[4*g +: 4];

    assign w_up_cnt[4*g +: 4] = !w_carry[g]  ? w_dig :
                                (w_dig == BCD_MAX) ? 4'd0 : w_dig + 4'd1;
    assign w_carry[g+1]       = w_carry[g] & (w_dig == BCD_MAX);

    assign w_dn_cnt[4*g +: 4] = !w_borrow[g] ? w_dig :
                                (w_dig == 4'd0) ? BCD_MAX : w_dig - 4'd1;
    assign w_borrow[g+1]      = w_borrow[g] & (w_dig == 4'd0);

    assign w_load[4*g +: 4]   = (w_ld > BCD_MAX) ? BCD_MAX : w_ld;

    // Digit is a leading zero when it and every higher digit are zero.
    assign w_lz[g]    = (w_dig == 4'd0) & w_lz[g+1];
    assign w_blank[g] = (BLANK_LZ != 0) && (g != 0) && w_lz[g];

    seg7_decode u_dec (
      .i_bcd   (w_dig),
      .i_blank (w_blank[g]),
      .o_seg   (w_seg[8*g +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_count <= '0;
      r_hex   <= '1;
    end else begin
      r_hex  <= w_seg;
      r_wrap <= 1'b0;
      if (w_mode == MODE_LOAD) begin
        r_pre   <= '0;
        r_tick  <= 1'b0;
        r_count <= w_load;
      end else begin
        if (en) begin
          r_pre  <= w_pre_last ? '0 : r_pre + PW'(1);
          r_tick <= w_pre_last;
        end else begin
          r_pre  <= '0;
          r_tick <= 1'b0;
        end
        if (w_advance) begin
          case (w_mode)
            MODE_UP: begin
              r_count <= w_up_cnt;
              r_wrap  <= w_carry[DIGITS];
            end
            MODE_DOWN: begin
              r_count <= w_dn_cnt;
              r_wrap  <= w_borrow[DIGITS];
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign count = r_count;
  assign hex   = r_hex;
  assign tick  = r_tick;
  assign wrap  = r_wrap;

endmodule
